// File: rtl/vec_lane_seq_if.sv
// vec_lane_seq_if -- request/ALU/result bundle for the vector lane sequencer.
//   start         request one whole-register operation
//   vsew          element width code (SEW = 8<<vsew, codes 4-7 reserved)
//   lane_result   combinational lane-ALU result for the current step
//   run           ALU enable, high during RUN steps
//   index         bit offset of the current chunk within vs2/vd
//   in_reg_offset chunk number within the current element
//   busy          high while an operation is in RUN or DONE
//   done          one-cycle completion pulse
//   err           reserved vsew seen; valid with done
//   vd_out        assembled destination register
// master: requester/ALU side; slave: the sequencer.
interface vec_lane_seq_if #(
   parameter int unsigned VLEN = 128
);
   logic            start;
   logic [2:0]      vsew;
   logic [63:0]     lane_result;
   logic            run;
   logic [9:0]      index;
   logic [3:0]      in_reg_offset;
   logic            busy;
   logic            done;
   logic            err;
   logic [VLEN-1:0] vd_out;

   modport master (
      output start, vsew, lane_result,
      input  run, index, in_reg_offset, busy, done, err, vd_out
   );

   modport slave (
      input  start, vsew, lane_result,
      output run, index, in_reg_offset, busy, done, err, vd_out
   );
endinterface

// File: rtl/vec_lane_seq.sv
// vec_lane_seq -- steps a lane ALU across one vector register, one chunk of
// W = min(SEW, CW) bits per cycle, and assembles the results into vd_out.
// Ports:
//   clk     clock, rising edge
//   resetn  synchronous active-low reset
//   bus     vec_lane_seq_if.slave (start/vsew/lane_result in;
//           run/index/in_reg_offset/busy/done/err/vd_out out)
// Parameters:
//   VLEN        vector register width in bits (must match the interface)
//   LANE_WIDTH  log2 of the lane chunk width CW (3..6 -> 8/16/32/64)
module vec_lane_seq #(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned LANE_WIDTH = 3'b100
) (
   input logic           clk,
   input logic           resetn,
   vec_lane_seq_if.slave bus
);

   localparam logic [2:0] LW_C = 3'(LANE_WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [1:0]      sew_r;
   logic [9:0]      k;
   logic            run_r;
   logic            busy_r;
   logic            done_r;
   logic            err_r;
   logic [9:0]      index_r;
   logic [3:0]      off_r;
   logic [VLEN-1:0] vd_r;

   // Per-step geometry derived from the latched element width.
   logic [2:0]      sew_lg;   // log2(SEW)
   logic [2:0]      lw;       // log2(W), W = min(SEW, CW)
   logic [2:0]      rlg;      // log2(SEW/W), chunks per element
   logic [3:0]      off_mask;
   logic [9:0]      last_k;
   logic [9:0]      k_nxt;
   logic [9:0]      idx_nxt;
   logic [3:0]      off_nxt;
   logic [6:0]      wbits;
   logic [63:0]     wmask;
   logic [VLEN-1:0] mask_v;
   logic [VLEN-1:0] data_v;
   logic [VLEN-1:0] vd_nxt;

   always_comb begin
      sew_lg   = {1'b0, sew_r} + 3'd3;
      lw       = (sew_lg > LW_C) ? LW_C : sew_lg;
      rlg      = sew_lg - lw;
      off_mask = (4'd1 << rlg) - 4'd1;
      last_k   = 10'((VLEN >> lw) - 1);
      k_nxt    = k + 10'd1;
      // index = k*W in both the narrow and the wide case
      idx_nxt  = k_nxt << lw;
      off_nxt  = k_nxt[3:0] & off_mask;
      // Variable-width part-select done as mask-and-merge; W=64 is the
      // one case where the shift would overflow, so it is special-cased.
      wbits    = 7'd1 << lw;
      wmask    = wbits[6] ? '1 : ((64'd1 << wbits) - 64'd1);
      mask_v   = VLEN'(wmask) << index_r;
      data_v   = VLEN'(bus.lane_result & wmask) << index_r;
      vd_nxt   = (vd_r & ~mask_v) | data_v;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= IDLE;
         sew_r   <= '0;
         k       <= '0;
         run_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
         index_r <= '0;
         off_r   <= '0;
         vd_r    <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  sew_r   <= bus.vsew[1:0];
                  vd_r    <= '0;
                  k       <= '0;
                  index_r <= '0;
                  off_r   <= '0;
                  busy_r  <= 1'b1;
                  if (bus.vsew[2]) begin
                     // reserved width: report straight away, no ALU steps
                     err_r  <= 1'b1;
                     done_r <= 1'b1;
                     state  <= DONE;
                  end else begin
                     err_r  <= 1'b0;
                     run_r  <= 1'b1;
                     state  <= RUN;
                  end
               end
            end
            RUN: begin
               vd_r <= vd_nxt;
               if (k == last_k) begin
                  run_r   <= 1'b0;
                  index_r <= '0;
                  off_r   <= '0;
                  done_r  <= 1'b1;
                  state   <= DONE;
               end else begin
                  k       <= k_nxt;
                  index_r <= idx_nxt;
                  off_r   <= off_nxt;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               k      <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.run           = run_r;
   assign bus.index         = index_r;
   assign bus.in_reg_offset = off_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.err           = err_r;
   assign bus.vd_out        = vd_r;

endmodule

// File: doc/vec_lane_seq.md
VEC_LANE_SEQ -- requirements
Module: vec_lane_seq

Interface
REQ-001 The module SHALL have parameter VLEN, default 128, meaning vector register width in bits.
REQ-002 The module SHALL have parameter LANE_WIDTH, default 3'b100, meaning lane chunk width CW = 2^LANE_WIDTH bits (8/16/32/64).
REQ-003 The module SHALL have ports, one per line:
 clk  in  1  clock; all state updates on rising edge.
 resetn  in  1  reset, synchronous, active-low.
 start  in  1  request one whole-register operation.
 vsew  in  3  element width code; SEW = 8<<vsew; 4-7 reserved.
 lane_result  in  64  combinational result from the lane ALU for the current step.
 run  out  1  ALU enable; high exactly during RUN steps.
 index  out  10  bit offset of the current chunk within vs2/vd.
 in_reg_offset  out  4  chunk number within the current element.
 busy  out  1  high in RUN and DONE.
 done  out  1  one-cycle completion pulse.
 err  out  1  reserved vsew; valid with done.
 vd_out  out  VLEN  assembled destination register.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE.
REQ-005 In IDLE, start=1 SHALL latch vsew, clear vd_out to 0, clear the step counter k, clear err, and go to RUN; if the latched vsew>3, the FSM SHALL go to DONE with err=1 and no RUN cycles.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 The step count SHALL be N = VLEN/SEW when SEW<=CW, else N = VLEN/CW.
REQ-008 For step k in RUN with SEW<=CW: index = k*SEW, in_reg_offset = 0.
REQ-009 For step k in RUN with SEW>CW: index = k*CW, in_reg_offset = k mod (SEW/CW); chunks SHALL be issued least-significant first, one per cycle, with no gaps, so the ALU's registered carry chains correctly.
REQ-010 Each RUN cycle SHALL write W = min(SEW,CW) bits lane_result[W-1:0] into vd_out[index +: W] at the clock edge; other bits SHALL be unchanged.
REQ-011 run SHALL be 1 only in RUN; index and in_reg_offset SHALL be 0 outside RUN.
REQ-012 After step N-1 the FSM SHALL go to DONE; DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-013 vd_out SHALL hold its value in IDLE until the next accepted start.
REQ-014 Latency: start accepted at cycle T, RUN spans T+1..T+N, done=1 at T+N+1, and a new start is accepted from T+N+2.
REQ-015 vsew SHALL be sampled only at start acceptance; changes during RUN SHALL have no effect.
REQ-016 index arithmetic SHALL use at least 10 bits, and no write SHALL address bits at or beyond VLEN.

Reset
REQ-017 When resetn=0 at a clock edge, the module SHALL enter IDLE with run=0, busy=0, done=0, err=0, index=0, in_reg_offset=0, k=0, and vd_out=0, including when reset occurs mid-RUN or in DONE.
REQ-018 start SHALL be ignored in any cycle with resetn=0.

Verification (VLEN=128, LANE_WIDTH=4, CW=16)
REQ-019 The bench SHALL cover:
 vsew=0, lane_result=8'(index/8+1) -> 16 RUN cycles, index 0,8,..,120, offset 0; done at T+17; vd_out bytes = 0x01..0x10 (byte0=0x01).
 vsew=1, lane_result=16'hA5A5 -> 8 RUN cycles, index 0,16,..,112, offset 0; vd_out = all 0xA5A5 halfwords.
 vsew=2 -> index 0,16,..,112 with offsets 0,1,0,1,..; vsew=3 -> offsets 0,1,2,3,0,1,2,3; vd_out equals the concatenated lane chunks.
 vsew=5 -> no run pulse; done and err high at T+1; vd_out = 0.
 start held high throughout a vsew=0 operation -> single operation; next acceptance at T+18; vsew changed mid-RUN -> no effect.
 resetn=0 at the fifth RUN cycle -> next cycle IDLE, all outputs 0; a fresh start completes normally.
